// File: rtl/programmable_clock_divider.sv
// programmable_clock_divider: run-time programmable high/low phase clock divider with
// glitch-free shadow reload at period boundaries and fast-clock edge strobes.
module programmable_clock_divider #(
    parameter int WIDTH     = 6,
    parameter int INIT_HIGH = 1,
    parameter int INIT_LOW  = 1,
    parameter int NEGEDGE   = 1
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] high_count,
    input  logic [WIDTH-1:0] low_count,
    output logic             clock_out,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic             load_ack,
    output logic [WIDTH-1:0] phase_count,
    output logic             running
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
    state_t state, state_n;
    logic clk, pending, start, clock_n, rise_n, fall_n;
    logic [WIDTH-1:0] active_high, active_low, shadow_high, shadow_low, counter_n;
    assign clk = (NEGEDGE != 0) ? ~clock_in : clock_in;
    // start covers both the IDLE launch and the enabled period boundary
    always_comb begin
        state_n   = state;
        counter_n = phase_count + 1'b1;
        clock_n   = clock_out;
        rise_n    = 1'b0;
        fall_n    = 1'b0;
        start     = 1'b0;
        case (state)
            IDLE: begin
                counter_n = '0;
                start     = enable;
            end
            HIGH: if (phase_count == active_high) begin
                state_n   = LOW;
                counter_n = '0;
                clock_n   = 1'b0;
                fall_n    = 1'b1;
            end
            default: if (phase_count == active_low) begin
                state_n   = IDLE;
                counter_n = '0;
                clock_n   = 1'b0;
                start     = enable;
            end
        endcase
        if (start) begin
            state_n = HIGH;
            clock_n = 1'b1;
            rise_n  = 1'b1;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            phase_count <= '0;
            clock_out   <= 1'b0;
            rise_tick   <= 1'b0;
            fall_tick   <= 1'b0;
            load_ack    <= 1'b0;
            running     <= 1'b0;
            pending     <= 1'b0;
            active_high <= WIDTH'(INIT_HIGH);
            active_low  <= WIDTH'(INIT_LOW);
            shadow_high <= WIDTH'(INIT_HIGH);
            shadow_low  <= WIDTH'(INIT_LOW);
        end else begin
            state       <= state_n;
            phase_count <= counter_n;
            clock_out   <= clock_n;
            rise_tick   <= rise_n;
            fall_tick   <= fall_n;
            running     <= state_n != IDLE;
            load_ack    <= start && pending;
            // a load coinciding with a transfer is held for the following boundary
            pending     <= load || (pending && !start);
            if (start && pending) begin
                active_high <= shadow_high;
                active_low  <= shadow_low;
            end
            if (load) begin
                shadow_high <= high_count;
                shadow_low  <= low_count;
            end
        end
    end
endmodule
